// File: rtl/seq_ser_pkg.sv
// -----------------------------------------------------------------------------
// seq_ser_pkg
//   Shared definitions for the bit serializer feeding the "101" detector.
//   - state_t     : FSM encoding (ST_IDLE, ST_SHIFT, ST_PARITY)
//   - even_parity : XOR-reduction of a word, zero-extended to PAR_MAX_W bits
//   Optional feature macro: SEQ_SER_PARITY_EN (only the top level uses it).
// -----------------------------------------------------------------------------
package seq_ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  // Widest word the parity helper covers. Zero-extension does not change the
  // XOR result, so any WIDTH up to this value can use the same function.
  localparam int unsigned PAR_MAX_W = 64;

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/seq_bit_serializer_shift.sv
// -----------------------------------------------------------------------------
// seq_shift_reg
//   WIDTH-bit load / shift-left register. A zero is shifted into bit 0.
//   Ports:
//     i_clk    in   clock, rising edge
//     i_reset  in   synchronous active-high reset (clears the register)
//     i_load   in   load i_data (has priority over i_shift)
//     i_shift  in   shift left by one
//     i_data   in   WIDTH-bit load value
//     o_msb    out  current bit WIDTH-1
// -----------------------------------------------------------------------------
module seq_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_data;
    end else if (i_shift) begin
      r_q <= {r_q[WIDTH-2:0], 1'b0};
    end
  end

  assign o_msb = r_q[WIDTH-1];

endmodule

// File: rtl/seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer
//   Accepts parallel words over valid/ready and shifts them out MSB-first, one
//   bit per clock, on o_ser_x. Words accepted back-to-back stream with no gap.
//   Optional feature macro: SEQ_SER_PARITY_EN appends one even-parity bit
//   (^word) after each word, so a word occupies WIDTH+1 cycles.
//
//   Handshake: a word transfers on the rising edge where i_in_valid and
//   o_in_ready are both high. o_in_ready is a function of state and bit count
//   only, never of i_in_valid; i_in_data is sampled only on that edge.
//
//   Ports:
//     i_clk        in   clock, rising edge
//     i_reset      in   synchronous active-high reset
//     i_in_data    in   WIDTH-bit parallel word
//     i_in_valid   in   i_in_data is valid
//     o_in_ready   out  a word can be accepted this cycle
//     o_ser_x      out  registered serial bit (IDLE_BIT when idle)
//     o_ser_valid  out  o_ser_x carries a payload or parity bit
//     o_word_done  out  high during the final bit of each word
// -----------------------------------------------------------------------------
module seq_bit_serializer
  import seq_ser_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_ser_x,
  output logic             o_ser_valid,
  output logic             o_word_done
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_bit_cnt;
  logic [CW-1:0]   w_bit_cnt_nxt;
  logic            r_ser_x;
  logic            w_ser_x_nxt;
  logic            w_load;
  logic            w_shift;
  logic            w_accept;
  logic            w_msb;
  logic            w_last_bit;

  // The MSB goes straight to r_ser_x on load; the shift register only holds
  // the bits still to be emitted, so its msb is always the next bit to send.
  seq_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  ({i_in_data[WIDTH-2:0], 1'b0}),
    .o_msb   (w_msb)
  );

  assign w_last_bit = (r_state == ST_SHIFT) && (r_bit_cnt == '0);

`ifdef SEQ_SER_PARITY_EN
  logic r_parity;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_parity <= 1'b0;
    end else if (w_load) begin
      r_parity <= even_parity(PAR_MAX_W'(i_in_data));
    end
  end

  assign o_in_ready  = (r_state == ST_IDLE) || (r_state == ST_PARITY);
  assign o_word_done = (r_state == ST_PARITY);
`else
  assign o_in_ready  = (r_state == ST_IDLE) || w_last_bit;
  assign o_word_done = w_last_bit;
`endif

  assign w_accept    = i_in_valid && o_in_ready;
  assign o_ser_valid = (r_state != ST_IDLE);
  assign o_ser_x     = r_ser_x;

  always_comb begin
    w_state_nxt   = ST_IDLE;
    w_bit_cnt_nxt = r_bit_cnt;
    w_ser_x_nxt   = IDLE_BIT;
    w_load        = 1'b0;
    w_shift       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load        = 1'b1;
          w_bit_cnt_nxt = CNT_LAST;
          w_state_nxt   = ST_SHIFT;
          w_ser_x_nxt   = i_in_data[WIDTH-1];
        end
      end

      ST_SHIFT: begin
        if (r_bit_cnt != '0) begin
          w_shift       = 1'b1;
          w_bit_cnt_nxt = r_bit_cnt - CW'(1);
          w_state_nxt   = ST_SHIFT;
          w_ser_x_nxt   = w_msb;
        end else begin
`ifdef SEQ_SER_PARITY_EN
          w_state_nxt = ST_PARITY;
          w_ser_x_nxt = r_parity;
`else
          // Reload on the last payload bit keeps the stream gapless.
          if (w_accept) begin
            w_load        = 1'b1;
            w_bit_cnt_nxt = CNT_LAST;
            w_state_nxt   = ST_SHIFT;
            w_ser_x_nxt   = i_in_data[WIDTH-1];
          end
`endif
        end
      end

`ifdef SEQ_SER_PARITY_EN
      ST_PARITY: begin
        if (w_accept) begin
          w_load        = 1'b1;
          w_bit_cnt_nxt = CNT_LAST;
          w_state_nxt   = ST_SHIFT;
          w_ser_x_nxt   = i_in_data[WIDTH-1];
        end
      end
`endif

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_ser_x   <= IDLE_BIT;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_ser_x   <= w_ser_x_nxt;
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_seq_bit_serializer
//   Bench for seq_bit_serializer (WIDTH=8, IDLE_BIT=0). The reference model is
//   a queue of {last, bit} entries: every accepted word appends its bits in
//   transmission order, and each clock cycle pops one entry. in_ready is
//   expected exactly when nothing remains queued after the current bit.
// -----------------------------------------------------------------------------
module tb_seq_bit_serializer;

  localparam int W = 8;
`ifdef SEQ_SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         ser_x;
  logic         ser_valid;
  logic         word_done;

  always #5 clk = ~clk;

  seq_bit_serializer #(.WIDTH(W), .IDLE_BIT(1'b0)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_in_data   (in_data),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .o_ser_x     (ser_x),
    .o_ser_valid (ser_valid),
    .o_word_done (word_done)
  );

  // ---------------- scoreboard state ----------------
  logic [1:0] exp_q[$];      // {last, bit}
  logic       m_ready = 1'b1;
  int         checks = 0;
  int         errors = 0;

  // ---------------- driver ----------------
  // Drives one cycle of inputs, advances past the rising edge, updates the
  // model and returns the expected {in_ready, ser_valid, ser_x, word_done}.
  task automatic drive_cycle(input logic v, input logic [W-1:0] d,
                             input logic rst, output logic [3:0] e);
    logic       acc;
    logic [1:0] b;
    acc      = v && m_ready && !rst;
    in_valid = v;
    in_data  = d;
    reset    = rst;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
    end else if (acc) begin
      for (int i = W - 1; i >= 0; i--)
        exp_q.push_back({(i == 0) && (PAR == 0), d[i]});
      if (PAR != 0) exp_q.push_back({1'b1, ^d});
    end
    if (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      e = {1'b0, 1'b1, b[0], b[1]};
    end else begin
      e = 4'b0000;
    end
    m_ready = (exp_q.size() == 0);
    e[3]    = m_ready;
  endtask

  function automatic logic [3:0] dut_outs();
    return {in_ready, ser_valid, ser_x, word_done};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [3:0] e;
    for (int c = 0; c < 2; c++) begin
      drive_cycle(1'b0, '0, 1'b1, e);
      checks++;
      if (dut_outs() !== 4'b1000) begin
        errors++;
        $display("FAIL reset c=%0d {rdy,vld,x,done} got=%b exp=%b", c, dut_outs(), 4'b1000);
      end
    end
  endtask

  task automatic test_single_word();
    logic [3:0]   e;
    logic [W-1:0] bits = '0;
    int           nb = 0;
    int           done_at = -1;
    for (int c = 0; c < 12; c++) begin
      // Data changes on non-accept cycles must be ignored.
      drive_cycle(c == 0, (c == 0) ? 8'hA5 : W'($urandom), 1'b0, e);
      checks++;
      if (dut_outs() !== e) begin
        errors++;
        $display("FAIL single c=%0d {rdy,vld,x,done} got=%b exp=%b", c, dut_outs(), e);
      end
      if (ser_valid && nb < W) begin
        bits = {bits[W-2:0], ser_x};
        nb++;
      end
      if (word_done && done_at < 0) done_at = c;
    end
    checks++;
    if (bits !== 8'hA5) begin
      errors++;
      $display("FAIL single_bits got=%h exp=%h", bits, 8'hA5);
    end
    checks++;
    if (done_at !== W - 1 + PAR) begin
      errors++;
      $display("FAIL single_done_cycle got=%0d exp=%0d", done_at, W - 1 + PAR);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    logic       acc;
    int         idx = 0;
    int         run = 0;
    int         max_run = 0;
    int         done1_c = -1;
    int         acc2_c = -1;
    for (int c = 0; c < 30; c++) begin
      acc = (idx < 2) && m_ready;
      if (acc && idx == 1) acc2_c = c;
      drive_cycle(idx < 2, (idx == 0) ? 8'hA5 : 8'h5A, 1'b0, e);
      if (acc) idx++;
      checks++;
      if (dut_outs() !== e) begin
        errors++;
        $display("FAIL b2b c=%0d {rdy,vld,x,done} got=%b exp=%b", c, dut_outs(), e);
      end
      run = ser_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (word_done && done1_c < 0) done1_c = c;
    end
    checks++;
    if (max_run !== 2 * (W + PAR)) begin
      errors++;
      $display("FAIL b2b_gapless run got=%0d exp=%0d", max_run, 2 * (W + PAR));
    end
    checks++;
    if (acc2_c !== done1_c + 1) begin
      errors++;
      $display("FAIL b2b_accept_edge got=%0d exp=%0d", acc2_c, done1_c + 1);
    end
  endtask

  task automatic test_detector_pattern();
    logic [3:0] e;
    logic       seq_bits[W];
    int         nb = 0;
    int         hits = 0;
    int         hit_end = -1;
    for (int c = 0; c < 12; c++) begin
      drive_cycle(c == 0, 8'h05, 1'b0, e);
      checks++;
      if (dut_outs() !== e) begin
        errors++;
        $display("FAIL detect c=%0d {rdy,vld,x,done} got=%b exp=%b", c, dut_outs(), e);
      end
      if (ser_valid && nb < W) begin
        seq_bits[nb] = ser_x;
        nb++;
      end
    end
    for (int i = 2; i < W; i++) begin
      if (seq_bits[i-2] == 1'b1 && seq_bits[i-1] == 1'b0 && seq_bits[i] == 1'b1) begin
        hits++;
        hit_end = i;
      end
    end
    checks++;
    if (hits !== 1 || hit_end !== W - 1) begin
      errors++;
      $display("FAIL detect_101 hits=%0d end=%0d exp hits=1 end=%0d", hits, hit_end, W - 1);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [3:0]   e;
    logic [W-1:0] bits = '0;
    int           nb = 0;
    drive_cycle(1'b1, 8'hFF, 1'b0, e);          // accept, bit 1 shown
    for (int c = 0; c < 3; c++) begin           // bits 2..4
      drive_cycle(1'b0, '0, 1'b0, e);
      checks++;
      if (dut_outs() !== e) begin
        errors++;
        $display("FAIL midreset_pre c=%0d got=%b exp=%b", c, dut_outs(), e);
      end
    end
    drive_cycle(1'b1, 8'h3C, 1'b1, e);          // reset during 4th bit
    checks++;
    if (dut_outs() !== 4'b1000) begin
      errors++;
      $display("FAIL midreset_idle got=%b exp=%b", dut_outs(), 4'b1000);
    end
    for (int c = 0; c < 12; c++) begin
      drive_cycle(c == 0, 8'h81, 1'b0, e);
      checks++;
      if (dut_outs() !== e) begin
        errors++;
        $display("FAIL midreset_post c=%0d got=%b exp=%b", c, dut_outs(), e);
      end
      if (ser_valid && nb < W) begin
        bits = {bits[W-2:0], ser_x};
        nb++;
      end
    end
    checks++;
    if (bits !== 8'h81) begin
      errors++;
      $display("FAIL midreset_word got=%h exp=%h", bits, 8'h81);
    end
  endtask

  task automatic test_random();
    logic [3:0] e;
    logic       v;
    logic       r;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 63) == 0);
      drive_cycle(v, W'($urandom), r, e);
      checks++;
      if (dut_outs() !== e) begin
        errors++;
        $display("FAIL random c=%0d {rdy,vld,x,done} got=%b exp=%b", c, dut_outs(), e);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_detector_pattern();
    test_reset_mid_word();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
